controlador_de_ataque: RTL and testbench

Clocked, parametrised successor of the attack manager for the battleship LED-matrix game. It accepts a player's shot at (coordColuna, coordLinha) on a confirm press and reveals the hidden map bit in the displayed matrix. It also records which cells have been fired at, rejects repeated or out-of-range shots, counts hits and attempts, and declares victory once every ship cell is found. It sits between the input/coordinate selector and the LED matrix driver.

---
 rtl/batalha_naval_pkg.sv | 19 +
 rtl/detector_de_borda.sv | 34 +++
 rtl/controlador_de_ataque.sv | 168 ++++++++++++++++
 tb/tb_controlador_de_ataque.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/batalha_naval_pkg.sv
// Shared definitions for the battleship attack manager: FSM encoding,
// counter width, board defaults and the cell-index helper.
package batalha_naval_pkg;

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] AVALIA   = 2'd1;
  localparam logic [1:0] VERIFICA = 2'd2;
  localparam logic [1:0] FIM      = 2'd3;

  localparam int CONT_W = 7;

  localparam int COLUNAS_PAD = 5;
  localparam int LINHAS_PAD  = 7;

  function automatic int indice(input int col, input int lin, input int linhas);
    return col * linhas + lin;
  endfunction

endpackage

// File: rtl/detector_de_borda.sv
// Two-flop synchroniser for the raw confirm button followed by a
// rising-edge detector producing a single-cycle pulse.
module detector_de_borda (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic pulso
);

  logic sinc1_q, sinc1_d;
  logic sinc2_q, sinc2_d;
  logic ant_q, ant_d;

  always_comb begin
    sinc1_d = entrada;
    sinc2_d = sinc1_q;
    ant_d   = sinc2_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1_q <= 1'b0;
      sinc2_q <= 1'b0;
      ant_q   <= 1'b0;
    end else begin
      sinc1_q <= sinc1_d;
      sinc2_q <= sinc2_d;
      ant_q   <= ant_d;
    end
  end

  assign pulso = sinc2_q & ~ant_q;

endmodule

// File: rtl/controlador_de_ataque.sv
// Battleship attack manager: validates shots, reveals hits, counts and
// detects victory. Optional attempt limit under LIMITE_TENTATIVAS_EN.
module controlador_de_ataque
  import batalha_naval_pkg::*;
#(
  parameter int COLUNAS        = COLUNAS_PAD,
  parameter int LINHAS         = LINHAS_PAD,
  parameter int CW             = 3,
  parameter int MAX_TENTATIVAS = 20
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      confirmar,
  input  logic [CW-1:0]             coordColuna,
  input  logic [CW-1:0]             coordLinha,
  input  logic [COLUNAS*LINHAS-1:0] mapa,
  output logic [COLUNAS*LINHAS-1:0] matriz,
  output logic [COLUNAS*LINHAS-1:0] tiros,
  output logic                      acerto,
  output logic                      erro,
  output logic                      invalido,
  output logic [CONT_W-1:0]         acertos,
  output logic [CONT_W-1:0]         tentativas,
  output logic                      fim_de_jogo,
  output logic                      vitoria
);

  localparam int N  = COLUNAS * LINHAS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CONT_W-1:0] CONT_MAX = '1;

  logic pulso;

  detector_de_borda u_borda (
    .clock   (clock),
    .reset   (reset),
    .entrada (confirmar),
    .pulso   (pulso)
  );

  logic [1:0]        estado_q, estado_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     lin_q, lin_d;
  logic [N-1:0]      matriz_q, matriz_d;
  logic [N-1:0]      tiros_q, tiros_d;
  logic [CONT_W-1:0] acertos_q, acertos_d;
  logic [CONT_W-1:0] tent_q, tent_d;
  logic              acerto_q, acerto_d;
  logic              erro_q, erro_d;
  logic              invalido_q, invalido_d;
  logic              fim_q, fim_d;
  logic              vit_q, vit_d;

  logic          em_faixa;
  logic [IW-1:0] idx;
  logic          venceu;

`ifndef LIMITE_TENTATIVAS_EN
  logic unused_limite;
  assign unused_limite = ^MAX_TENTATIVAS;
`endif

  always_comb begin
    em_faixa = (int'(col_q) < COLUNAS) && (int'(lin_q) < LINHAS);
    idx      = em_faixa ? IW'(indice(int'(col_q), int'(lin_q), LINHAS)) : '0;
    venceu   = ((mapa & ~matriz_q) == '0) && (mapa != '0);

    estado_d   = estado_q;
    col_d      = col_q;
    lin_d      = lin_q;
    matriz_d   = matriz_q;
    tiros_d    = tiros_q;
    acertos_d  = acertos_q;
    tent_d     = tent_q;
    acerto_d   = 1'b0;
    erro_d     = 1'b0;
    invalido_d = 1'b0;
    fim_d      = fim_q;
    vit_d      = vit_q;

    unique case (estado_q)
      OCIOSO: begin
        if (pulso && enable && !fim_q) begin
          col_d    = coordColuna;
          lin_d    = coordLinha;
          estado_d = AVALIA;
        end
      end
      AVALIA: begin
        if (!em_faixa || tiros_q[idx]) begin
          invalido_d = 1'b1;
          estado_d   = OCIOSO;
        end else begin
          tiros_d[idx]  = 1'b1;
          matriz_d[idx] = mapa[idx];
          if (tent_q != CONT_MAX) tent_d = tent_q + 1'b1;
          if (mapa[idx]) begin
            acerto_d = 1'b1;
            if (acertos_q != CONT_MAX) acertos_d = acertos_q + 1'b1;
          end else begin
            erro_d = 1'b1;
          end
          estado_d = VERIFICA;
        end
      end
      VERIFICA: begin
        if (venceu) begin
          vit_d    = 1'b1;
          fim_d    = 1'b1;
          estado_d = FIM;
        end
`ifdef LIMITE_TENTATIVAS_EN
        else if (int'(tent_q) == MAX_TENTATIVAS) begin
          fim_d    = 1'b1;
          estado_d = FIM;
        end
`endif
        else begin
          estado_d = OCIOSO;
        end
      end
      FIM:     estado_d = FIM;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      col_q      <= '0;
      lin_q      <= '0;
      matriz_q   <= '0;
      tiros_q    <= '0;
      acertos_q  <= '0;
      tent_q     <= '0;
      acerto_q   <= 1'b0;
      erro_q     <= 1'b0;
      invalido_q <= 1'b0;
      fim_q      <= 1'b0;
      vit_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      col_q      <= col_d;
      lin_q      <= lin_d;
      matriz_q   <= matriz_d;
      tiros_q    <= tiros_d;
      acertos_q  <= acertos_d;
      tent_q     <= tent_d;
      acerto_q   <= acerto_d;
      erro_q     <= erro_d;
      invalido_q <= invalido_d;
      fim_q      <= fim_d;
      vit_q      <= vit_d;
    end
  end

  assign matriz      = matriz_q;
  assign tiros       = tiros_q;
  assign acerto      = acerto_q;
  assign erro        = erro_q;
  assign invalido    = invalido_q;
  assign acertos     = acertos_q;
  assign tentativas  = tent_q;
  assign fim_de_jogo = fim_q;
  assign vitoria     = vit_q;

endmodule

// File: tb/tb_controlador_de_ataque.sv
// Directed bench for controlador_de_ataque (default 5x7 board).
module tb_controlador_de_ataque;

  localparam int COLUNAS = 5;
  localparam int LINHAS  = 7;
  localparam int CW      = 3;
  localparam int N       = COLUNAS * LINHAS;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          confirmar;
  logic [CW-1:0] coordColuna;
  logic [CW-1:0] coordLinha;
  logic [N-1:0]  mapa;
  logic [N-1:0]  matriz;
  logic [N-1:0]  tiros;
  logic          acerto;
  logic          erro;
  logic          invalido;
  logic [6:0]    acertos;
  logic [6:0]    tentativas;
  logic          fim_de_jogo;
  logic          vitoria;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  controlador_de_ataque #(
    .COLUNAS        (COLUNAS),
    .LINHAS         (LINHAS),
    .CW             (CW),
    .MAX_TENTATIVAS (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .confirmar   (confirmar),
    .coordColuna (coordColuna),
    .coordLinha  (coordLinha),
    .mapa        (mapa),
    .matriz      (matriz),
    .tiros       (tiros),
    .acerto      (acerto),
    .erro        (erro),
    .invalido    (invalido),
    .acertos     (acertos),
    .tentativas  (tentativas),
    .fim_de_jogo (fim_de_jogo),
    .vitoria     (vitoria)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // pulses {acerto,erro,invalido} checked 4 cycles after press,
  // {fim_de_jogo,vitoria} one cycle later
  task automatic tiro(input string tag, input int col, input int lin,
                      input logic [2:0] exp_p, input logic [1:0] exp_fv);
    @(posedge clock); #1;
    coordColuna = CW'(col);
    coordLinha  = CW'(lin);
    confirmar   = 1'b1;
    repeat (3) @(posedge clock);
    #1 chk({tag, "_cedo"}, {acerto, erro, invalido}, 3'b000);
    @(posedge clock);
    #1 chk({tag, "_pulso"}, {acerto, erro, invalido}, exp_p);
    @(posedge clock);
    #1 chk({tag, "_fim"}, {fim_de_jogo, vitoria}, exp_fv);
    confirmar = 1'b0;
    repeat (4) @(posedge clock);
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    confirmar   = 1'b0;
    coordColuna = '0;
    coordLinha  = '0;
    mapa        = N'(35'h0_0000_1071);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_matriz", matriz, '0);
    chk("rst_tiros", tiros, '0);
    chk("rst_cont", {acertos, tentativas}, '0);
    chk("rst_flags", {acerto, erro, invalido, fim_de_jogo, vitoria}, '0);
    reset = 1'b0;

`ifdef LIMITE_TENTATIVAS_EN
    tiro("agua1", 1, 0, 3'b010, 2'b00);
    tiro("agua2", 2, 0, 3'b010, 2'b00);
    tiro("agua3", 3, 0, 3'b010, 2'b10);
    chk("lim_tent", tentativas, 7'd3);
    tiro("apos_limite", 0, 0, 3'b000, 2'b10);
    chk("lim_tent2", tentativas, 7'd3);
    chk("lim_matriz", matriz, '0);
`else
    tiro("tiro00", 0, 0, 3'b100, 2'b00);
    chk("t1_matriz", matriz, N'(1));
    chk("t1_tiros", tiros, N'(1));
    chk("t1_cont", {acertos, tentativas}, {7'd1, 7'd1});

    tiro("repetido", 0, 0, 3'b001, 2'b00);
    chk("rep_tent", tentativas, 7'd1);
    chk("rep_matriz", matriz, N'(1));
    tiro("col5", 5, 0, 3'b001, 2'b00);
    tiro("lin7", 0, 7, 3'b001, 2'b00);
    chk("fora_tent", tentativas, 7'd1);

    // button held 50 cycles on water cell (1,0) -> idx 7
    @(posedge clock); #1;
    coordColuna = 3'd1;
    coordLinha  = 3'd0;
    confirmar   = 1'b1;
    repeat (50) @(posedge clock);
    #1 chk("seg_tent", tentativas, 7'd2);
    chk("seg_tiros", tiros, N'(35'h81));
    confirmar = 1'b0;
    repeat (4) @(posedge clock);

    enable = 1'b0;
    tiro("desab", 2, 0, 3'b000, 2'b00);
    chk("desab_tent", tentativas, 7'd2);
    chk("desab_tiros", tiros, N'(35'h81));
    enable = 1'b1;

    tiro("a04", 0, 4, 3'b100, 2'b00);
    tiro("agua33", 3, 3, 3'b010, 2'b00);
    tiro("a05", 0, 5, 3'b100, 2'b00);
    tiro("a06", 0, 6, 3'b100, 2'b00);
    tiro("a15", 1, 5, 3'b100, 2'b11);
    chk("vit_cont", {acertos, tentativas}, {7'd5, 7'd7});
    chk("vit_matriz", matriz, N'(35'h1071));
    chk("vit_tiros", tiros, N'(35'h0_0100_10F1));
    tiro("pos_fim", 4, 6, 3'b000, 2'b11);
    chk("pos_fim_tent", tentativas, 7'd7);

    // reset with a shot sitting in AVALIA
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    coordColuna = 3'd0;
    coordLinha  = 3'd0;
    confirmar   = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rav_matriz", {matriz, tiros}, '0);
    chk("rav_flags", {acerto, erro, invalido, fim_de_jogo, vitoria,
                      acertos, tentativas}, '0);
    confirmar = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    tiro("pos_rst", 0, 0, 3'b100, 2'b00);
    chk("pos_rst_cont", {acertos, tentativas}, {7'd1, 7'd1});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
